obc_shift_accumulator: RTL and testbench

//  Bit-serial shift-accumulate stage directly downstream of the OBC ROM/sign-combine stage of the 16-point DFT.
//  - Consumes one signed DW-bit partial sum (romout) per bit-slice, MSB slice first.
//  - Drives the ROM stage's mode bit m (high on the MSB slice).
//  - After NBITS slices, adds the OBC offset term and presents one DFT output word on a valid/ready handshake.

---
 rtl/obc_dft_pkg.sv | 21 ++
 rtl/obc_acc_sat.sv | 27 ++
 rtl/obc_shift_accumulator.sv | 133 +++++++++++++
 tb/tb_obc_shift_accumulator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obc_dft_pkg.sv
// Shared constants and state encoding for the OBC 16-point DFT datapath.
// Consumed by obc_shift_accumulator and obc_acc_sat.
package obc_dft_pkg;

  localparam int DW      = 32;
  localparam int NBITS   = 16;
  localparam int AW      = 48;
  localparam int SLICE_W = $clog2(NBITS);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  // Sign-extend a DW-bit two's complement word to the accumulator width.
  function automatic logic signed [AW-1:0] sext_dw(input logic [DW-1:0] v);
    return {{(AW-DW){v[DW-1]}}, v};
  endfunction

endpackage

// File: rtl/obc_acc_sat.sv
// Combinational clamp of an AW-bit signed sum to the signed DW range.
// Only instantiated when OBC_ACC_SAT_EN is defined.
module obc_acc_sat
  import obc_dft_pkg::*;
(
  input  logic [AW-1:0] sum,
  output logic [AW-1:0] clamped,
  output logic          sat
);

  localparam logic [AW-1:0] MAX_VAL = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic [AW-1:0] MIN_VAL = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // The sum fits in DW bits iff every bit from DW-1 upward equals the sign.
  logic [AW-DW:0] upper;
  assign upper = sum[AW-1:DW-1];

  always_comb begin
    clamped = sum;
    sat     = 1'b0;
    if (!(&upper) && (|upper)) begin
      sat     = 1'b1;
      clamped = sum[AW-1] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/obc_shift_accumulator.sv
// Bit-serial shift-accumulate stage after the OBC ROM/sign-combine stage.
// Optional output clamp to the DW range is enabled by defining OBC_ACC_SAT_EN.
module obc_shift_accumulator
  import obc_dft_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DW-1:0]      offset,
  input  logic               in_valid,
  input  logic [DW-1:0]      romout,
  output logic               m_out,
  output logic [SLICE_W-1:0] slice_idx,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AW-1:0]      result,
  output logic               sat
);

  state_t state, state_next;

  logic signed [AW-1:0] acc;
  logic        [DW-1:0] offset_reg;

  logic begin_xfer;
  logic take_slice;
  logic last_slice;
  logic release_out;

  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] final_sum;
  logic        [AW-1:0] final_word;

  // The MSB slice carries negative weight; the ROM stage needs m on it.
  assign m_out = (state == ACCUM) && (slice_idx == '0);
  assign busy  = (state != IDLE);

  assign acc_next  = (acc <<< 1) + sext_dw(romout);
  assign final_sum = acc_next + sext_dw(offset_reg);

`ifdef OBC_ACC_SAT_EN
  logic final_sat;
  logic sat_q;

  obc_acc_sat u_sat (
    .sum     (final_sum),
    .clamped (final_word),
    .sat     (final_sat)
  );

  assign sat = sat_q;
`else
  assign final_word = final_sum;
  assign sat        = 1'b0;
`endif

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    begin_xfer  = 1'b0;
    take_slice  = 1'b0;
    last_slice  = 1'b0;
    release_out = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          begin_xfer = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          take_slice = 1'b1;
          if (slice_idx == SLICE_W'(NBITS-1)) begin
            last_slice = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          release_out = 1'b1;
          begin_xfer  = start;
          state_next  = start ? ACCUM : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      offset_reg <= '0;
      slice_idx  <= '0;
      result     <= '0;
      out_valid  <= 1'b0;
`ifdef OBC_ACC_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      if (release_out) out_valid <= 1'b0;

      if (begin_xfer) begin
        acc        <= '0;
        slice_idx  <= '0;
        offset_reg <= offset;
      end else if (take_slice) begin
        if (last_slice) begin
          result    <= final_word;
          out_valid <= 1'b1;
          slice_idx <= '0;
`ifdef OBC_ACC_SAT_EN
          sat_q     <= final_sat;
`endif
        end else begin
          acc       <= acc_next;
          slice_idx <= slice_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Self-checking bench for obc_shift_accumulator: directed cases plus randomized
// transforms checked against an arithmetic model of the weighted slice sum.
module tb_obc_shift_accumulator;
  import obc_dft_pkg::*;

  logic               clk;
  logic               rst;
  logic               start;
  logic [DW-1:0]      offset;
  logic               in_valid;
  logic [DW-1:0]      romout;
  logic               m_out;
  logic [SLICE_W-1:0] slice_idx;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [AW-1:0]      result;
  logic               sat;

  int n_checks = 0;
  int n_pass   = 0;

  obc_shift_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .offset    (offset),
    .in_valid  (in_valid),
    .romout    (romout),
    .m_out     (m_out),
    .slice_idx (slice_idx),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference: result = sum_i romout_i * 2^(NBITS-1-i) + offset, then optional clamp.
  function automatic longint ref_sum(input logic [DW-1:0] rom[NBITS], input logic [DW-1:0] off);
    longint s = 0;
    for (int i = 0; i < NBITS; i++)
      s += longint'($signed(rom[i])) * (longint'(1) << (NBITS-1-i));
    s += longint'($signed(off));
    return s;
  endfunction

  task automatic expected(input logic [DW-1:0] rom[NBITS], input logic [DW-1:0] off,
                          output logic [AW-1:0] exp_res, output logic exp_sat);
    longint s;
    longint hi;
    longint lo;
    s  = ref_sum(rom, off);
    hi = (longint'(1) << (DW-1)) - 1;
    lo = -(longint'(1) << (DW-1));
    exp_sat = 1'b0;
`ifdef OBC_ACC_SAT_EN
    if (s > hi) begin s = hi; exp_sat = 1'b1; end
    if (s < lo) begin s = lo; exp_sat = 1'b1; end
`endif
    exp_res = s[AW-1:0];
  endtask

  task automatic pulse_start(input logic [DW-1:0] off);
    start  = 1'b1;
    offset = off;
    @(negedge clk);
    start  = 1'b0;
    offset = $urandom;
  endtask

  // Feeds all slices; stall_len idle cycles are inserted before slice stall_at.
  task automatic feed(input logic [DW-1:0] rom[NBITS], input int stall_at, input int stall_len);
    for (int i = 0; i < NBITS; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          in_valid = 1'b0;
          romout   = $urandom;
          check("stall_slice_idx", 64'(slice_idx), 64'(i));
          check("stall_m_out", 64'(m_out), 64'(i == 0));
          @(negedge clk);
        end
      end
      check("slice_idx", 64'(slice_idx), 64'(i));
      check("m_out", 64'(m_out), 64'(i == 0));
      check("busy_accum", 64'(busy), 64'(1));
      check("out_valid_early", 64'(out_valid), 64'(0));
      in_valid = 1'b1;
      romout   = rom[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    romout   = $urandom;
  endtask

  task automatic check_result(input string tag, input logic [DW-1:0] rom[NBITS], input logic [DW-1:0] off);
    logic [AW-1:0] er;
    logic          es;
    expected(rom, off, er, es);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_sat"}, 64'(sat), 64'(es));
  endtask

  // Waits in HOLD with start/in_valid noise, then releases; optional back-to-back start.
  task automatic hold_release(input int wait_cycles, input bit b2b, input logic [DW-1:0] next_off);
    logic [AW-1:0] held;
    held = result;
    for (int k = 0; k < wait_cycles; k++) begin
      out_ready = 1'b0;
      start     = (k % 2 == 0);
      offset    = $urandom;
      in_valid  = 1'b1;
      romout    = $urandom;
      @(negedge clk);
      check("hold_out_valid", 64'(out_valid), 64'(1));
      check("hold_result", 64'(result), 64'(held));
      check("hold_busy", 64'(busy), 64'(1));
      check("hold_m_out", 64'(m_out), 64'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = b2b;
    offset    = next_off;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    offset    = $urandom;
    check("rel_out_valid", 64'(out_valid), 64'(0));
    check("rel_busy", 64'(busy), 64'(b2b));
    check("rel_m_out", 64'(m_out), 64'(b2b));
    check("rel_slice_idx", 64'(slice_idx), 64'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_result"}, 64'(result), 64'(0));
    check({tag, "_sat"}, 64'(sat), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_m_out"}, 64'(m_out), 64'(0));
    check({tag, "_slice_idx"}, 64'(slice_idx), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] rom[NBITS];
    logic [DW-1:0] off;
    logic [DW-1:0] next_off;
    bit            pending;
    bit            b2b;

    rst = 1'b1; start = 1'b0; offset = '0; in_valid = 1'b0; romout = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Unit slices, no offset.
    foreach (rom[i]) rom[i] = 32'd1;
    pulse_start(32'd0);
    feed(rom, -1, 0);
    check_result("t1", rom, 32'd0);
    hold_release(0, 1'b0, '0);

    // All -1 slices with a positive offset.
    foreach (rom[i]) rom[i] = 32'hFFFF_FFFF;
    pulse_start(32'd5);
    feed(rom, -1, 0);
    check_result("t2", rom, 32'd5);
    hold_release(1, 1'b0, '0);

    // Three stall cycles after slice 6.
    foreach (rom[i]) rom[i] = 32'd1;
    pulse_start(32'd0);
    feed(rom, 7, 3);
    check_result("t3", rom, 32'd0);
    hold_release(0, 1'b0, '0);

    // Long HOLD with start noise, then back-to-back start.
    pulse_start(32'd0);
    feed(rom, -1, 0);
    check_result("t4a", rom, 32'd0);
    off = $urandom;
    hold_release(4, 1'b1, off);
    foreach (rom[i]) rom[i] = $urandom;
    feed(rom, 0, 2);
    check_result("t4b", rom, off);
    hold_release(0, 1'b0, '0);

    // Reset in the middle of a transform.
    pulse_start(32'd9);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      romout   = $urandom;
      @(negedge clk);
    end
    check("t5_slice_idx", 64'(slice_idx), 64'(7));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check_reset_state("t5_rst");
    @(negedge clk);
    check("t5_idle_busy", 64'(busy), 64'(0));
    foreach (rom[i]) rom[i] = 32'd1;
    pulse_start(32'd0);
    feed(rom, -1, 0);
    check_result("t5_rerun", rom, 32'd0);
    hold_release(0, 1'b0, '0);

    // Largest positive slices: exceeds the DW range.
    foreach (rom[i]) rom[i] = 32'h7FFF_FFFF;
    pulse_start(32'd0);
    feed(rom, -1, 0);
    check_result("t6", rom, 32'd0);
    hold_release(0, 1'b0, '0);

    // Randomized transforms with random stalls, hold times and back-to-back starts.
    pending = 1'b0;
    for (int n = 0; n < 12; n++) begin
      foreach (rom[i]) begin
        case ($urandom_range(0, 3))
          0:       rom[i] = 32'h7FFF_FFFF;
          1:       rom[i] = 32'h8000_0000;
          default: rom[i] = $urandom;
        endcase
      end
      if (!pending) begin
        off = $urandom;
        pulse_start(off);
      end
      feed(rom, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NBITS-1)) : -1,
           int'($urandom_range(1, 3)));
      check_result("rand", rom, off);
      b2b      = ($urandom_range(0, 1) == 1) && (n != 11);
      next_off = $urandom;
      hold_release(int'($urandom_range(0, 3)), b2b, next_off);
      pending = b2b;
      off     = next_off;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
